// File: rtl/bank_rtn_tx_if.sv
// Read-return interface of one SRAM bank: controller response side in, crossbar return side out.
// master is the transmitter block; slave is whatever sits around it (bank controller + crossbar).
// ROB_WIDTH falls back to 8 when the surrounding build does not define it.
`ifndef ROB_WIDTH
`define ROB_WIDTH 8
`endif

interface bank_rtn_tx_if #(
  parameter int DEPTH = 4,
  parameter int ROB_W = `ROB_WIDTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  // bank controller response side
  logic             sram_rsp_valid;
  logic             sram_rsp_ready;
  logic [1:0]       sram_rsp_chl_id;
  logic [ROB_W-1:0] sram_rsp_rob_id;
  logic [127:0]     sram_rsp_data;

  // crossbar return side
  logic             d_bank_valid;
  logic             d_bank_enable;
  logic [1:0]       d_bank_chl_id;
  logic [ROB_W-1:0] d_bank_rob_id;
  logic [127:0]     d_bank_data;

  // status
  logic [CW-1:0]    fifo_cnt;
  logic             err_bad_chl;

  modport master (
    input  sram_rsp_valid, sram_rsp_chl_id, sram_rsp_rob_id, sram_rsp_data,
    output sram_rsp_ready,
    output d_bank_valid, d_bank_chl_id, d_bank_rob_id, d_bank_data,
    input  d_bank_enable,
    output fifo_cnt, err_bad_chl
  );

  modport slave (
    output sram_rsp_valid, sram_rsp_chl_id, sram_rsp_rob_id, sram_rsp_data,
    input  sram_rsp_ready,
    input  d_bank_valid, d_bank_chl_id, d_bank_rob_id, d_bank_data,
    output d_bank_enable,
    input  fifo_cnt, err_bad_chl
  );
endinterface

// File: rtl/bank_rtn_tx.sv
// Per-bank read-return transmitter: FIFO of read responses feeding a registered d_bank_* beat.
// Latency: accept in N -> d_bank_valid in N+2 (N+1 when BANK_RTN_BYPASS_EN is defined and the path is idle).
// Backpressure: d_bank_* frozen while valid & !enable; sram_rsp_ready depends only on the FIFO count register.
`ifndef ROB_WIDTH
`define ROB_WIDTH 8
`endif

module bank_rtn_tx #(
  parameter int DEPTH = 4,
  parameter int ROB_W = `ROB_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  bank_rtn_tx_if.master  io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [1:0]       chl;
    logic [ROB_W-1:0] rob;
    logic [127:0]     dat;
  } beat_t;

  // storage and state
  beat_t         mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_vld_q, out_vld_d;
  beat_t         out_q, out_d;
  logic          err_q, err_d;

  // per-cycle decisions
  beat_t in_beat;
  logic  rdy;
  logic  acc;
  logic  legal;
  logic  out_free;
  logic  fifo_empty;
  logic  push;
  logic  pop;
  logic  byp;

  assign in_beat    = {io.sram_rsp_chl_id, io.sram_rsp_rob_id, io.sram_rsp_data};

  // Ready comes from the count register alone, so a full FIFO stays not-ready
  // in the cycle it pops; the freed slot is offered one cycle later.
  assign rdy        = (cnt_q != CW'(DEPTH));
  assign acc        = io.sram_rsp_valid & rdy;
  assign legal      = (io.sram_rsp_chl_id != 2'd3);
  assign out_free   = ~out_vld_q | io.d_bank_enable;
  assign fifo_empty = (cnt_q == '0);

`ifdef BANK_RTN_BYPASS_EN
  // An idle path lets a legal beat skip the FIFO; with an empty FIFO this cannot reorder.
  assign byp        = acc & legal & fifo_empty & out_free;
`else
  assign byp        = 1'b0;
`endif

  // Channel 3 beats are consumed (handshake completes) but never stored.
  assign push       = acc & legal & ~byp;
  assign pop        = out_free & ~fifo_empty;

  // Next-state for pointers, count, output register and the sticky error flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    err_d     = err_q | (acc & ~legal);

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // FIFO head has priority over the bypass beat; the bypass is only taken
    // when the FIFO is empty, so both never compete in practice. When nothing
    // loads, only valid drops and the payload keeps its last value.
    if (pop) begin
      out_vld_d = 1'b1;
      out_d     = mem_q[rd_ptr_q];
    end else if (byp) begin
      out_vld_d = 1'b1;
      out_d     = in_beat;
    end else if (out_free) begin
      out_vld_d = 1'b0;
    end
  end

  // Control state and output register, synchronously cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  // Payload storage; stale entries after reset are unreachable because the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_beat;
    end
  end

  assign io.sram_rsp_ready = rdy;
  assign io.d_bank_valid   = out_vld_q;
  assign io.d_bank_chl_id  = out_q.chl;
  assign io.d_bank_rob_id  = out_q.rob;
  assign io.d_bank_data    = out_q.dat;
  assign io.fifo_cnt       = cnt_q;
  assign io.err_bad_chl    = err_q;

endmodule

// File: tb/tb_bank_rtn_tx.sv
// Bench for bank_rtn_tx: directed scenarios plus a randomized wrap-around stream,
// every cycle compared against a queue-based model of the read-return path.
module tb_bank_rtn_tx;

  localparam int DEPTH = 4;
  localparam int ROB_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef BANK_RTN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]       chl;
    logic [ROB_W-1:0] rob;
    logic [127:0]     dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  bank_rtn_tx_if #(.DEPTH(DEPTH), .ROB_W(ROB_W)) bus ();

  bank_rtn_tx #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: FIFO contents, output register, sticky error
  beat_t            m_fifo [$];
  logic             m_vld;
  beat_t            m_out;
  logic             m_err;
  logic [ROB_W-1:0] delivered [$];
  logic             obs_v;

  task automatic chk(input string tag, input logic [137:0] obs, input logic [137:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic r, input logic v, input logic [1:0] c,
                      input logic [ROB_W-1:0] rb, input logic [127:0] d, input logic e);
    logic  m_rdy, acc, legal, free, byp;
    beat_t in_b;
    rst                 = r;
    bus.sram_rsp_valid  = v;
    bus.sram_rsp_chl_id = c;
    bus.sram_rsp_rob_id = rb;
    bus.sram_rsp_data   = d;
    bus.d_bank_enable   = e;
    @(negedge clk);
    m_rdy = (m_fifo.size() != DEPTH);
    chk("valid", 138'(bus.d_bank_valid), 138'(m_vld));
    chk("chl",   138'(bus.d_bank_chl_id), 138'(m_out.chl));
    chk("rob",   138'(bus.d_bank_rob_id), 138'(m_out.rob));
    chk("data",  138'(bus.d_bank_data), 138'(m_out.dat));
    chk("ready", 138'(bus.sram_rsp_ready), 138'(m_rdy));
    chk("cnt",   138'(bus.fifo_cnt), 138'(m_fifo.size()));
    chk("err",   138'(bus.err_bad_chl), 138'(m_err));
    obs_v = bus.d_bank_valid;
    if (!r && bus.d_bank_valid === 1'b1 && e) delivered.push_back(bus.d_bank_rob_id);
    if (r) begin
      m_fifo.delete();
      m_vld = 1'b0;
      m_out = '0;
      m_err = 1'b0;
    end else begin
      in_b  = {c, rb, d};
      acc   = v && m_rdy;
      legal = (c != 2'd3);
      free  = !m_vld || e;
      byp   = BYP && acc && legal && (m_fifo.size() == 0) && free;
      if (acc && !legal) m_err = 1'b1;
      if (free && m_fifo.size() > 0) begin
        m_out = m_fifo.pop_front();
        m_vld = 1'b1;
      end else if (byp) begin
        m_out = in_b;
        m_vld = 1'b1;
      end else if (free) begin
        m_vld = 1'b0;
      end
      if (acc && legal && !byp) m_fifo.push_back(in_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic e);
    step(1'b0, 1'b0, 2'd0, '0, '0, e);
  endtask

  // Drain with enable held high, bounded by a cycle budget.
  task automatic drain();
    for (int k = 0; k < 40 && (m_vld || m_fifo.size() > 0); k++) idle(1'b1);
    chk("drain_empty", 138'(m_vld || m_fifo.size() > 0), 138'(0));
    idle(1'b1);
  endtask

  int               sent;
  logic [ROB_W-1:0] next_rob;
  logic             v_r, e_r, pre_rdy;

  initial begin
    m_vld = 1'b0;
    m_out = '0;
    m_err = 1'b0;
    rst = 1'b1;
    bus.sram_rsp_valid = 1'b0;
    bus.sram_rsp_chl_id = '0;
    bus.sram_rsp_rob_id = '0;
    bus.sram_rsp_data = '0;
    bus.d_bank_enable = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    step(1'b1, 1'b0, 2'd0, '0, '0, 1'b0);
    idle(1'b0);
    chk("rst_ready", 138'(bus.sram_rsp_ready), 138'(1));
    chk("rst_cnt", 138'(bus.fifo_cnt), 138'(0));

    // single beat: valid pulses one cycle at N+2 (N+1 with bypass)
    delivered.delete();
    step(1'b0, 1'b1, 2'd1, 8'd5, {16{8'hA5}}, 1'b1);
    idle(1'b1);
    chk("single_n1", 138'(obs_v), 138'(BYP));
    idle(1'b1);
    chk("single_n2", 138'(obs_v), 138'(!BYP));
    idle(1'b1);
    chk("single_n3", 138'(obs_v), 138'(0));
    chk("single_cnt", 138'(bus.fifo_cnt), 138'(0));
    chk("single_n", 138'(delivered.size()), 138'(1));
    if (delivered.size() == 1) chk("single_rob", 138'(delivered[0]), 138'(5));

    // backpressure fill: 5 accepted, 6th refused, output frozen on rob 0
    delivered.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'(i % 3), ROB_W'(i), rnd_data(), 1'b0);
    idle(1'b0);
    chk("full_ready", 138'(bus.sram_rsp_ready), 138'(0));
    chk("full_cnt", 138'(bus.fifo_cnt), 138'(DEPTH));
    chk("full_head", 138'(bus.d_bank_rob_id), 138'(0));

    // push/pop at full: no accept this cycle, cnt 3 next cycle, accepted then
    step(1'b0, 1'b1, 2'd2, 8'd5, rnd_data(), 1'b1);
    chk("pp_cnt_next", 138'(bus.fifo_cnt), 138'(DEPTH - 1));
    chk("pp_ready_next", 138'(bus.sram_rsp_ready), 138'(1));
    step(1'b0, 1'b1, 2'd2, 8'd5, rnd_data(), 1'b1);
    drain();
    chk("bp_n", 138'(delivered.size()), 138'(6));
    for (int i = 0; i < 6 && i < delivered.size(); i++)
      chk("bp_order", 138'(delivered[i]), 138'(i));

    // illegal channel between rob 7 and rob 8
    delivered.delete();
    step(1'b0, 1'b1, 2'd0, 8'd7, rnd_data(), 1'b1);
    step(1'b0, 1'b1, 2'd3, 8'd9, rnd_data(), 1'b1);
    step(1'b0, 1'b1, 2'd2, 8'd8, rnd_data(), 1'b1);
    chk("bad_chl_set", 138'(bus.err_bad_chl), 138'(1));
    drain();
    idle(1'b1);
    chk("bad_chl_sticky", 138'(bus.err_bad_chl), 138'(1));
    chk("ill_n", 138'(delivered.size()), 138'(2));
    if (delivered.size() == 2) begin
      chk("ill_first", 138'(delivered[0]), 138'(7));
      chk("ill_second", 138'(delivered[1]), 138'(8));
    end

    // wrap-around: 3*DEPTH beats, random valid gaps and enable stalls
    delivered.delete();
    sent = 0;
    next_rob = 8'd30;
    for (int k = 0; k < 400 && (sent < 3 * DEPTH || m_vld || m_fifo.size() > 0); k++) begin
      v_r = (sent < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
      e_r = ($urandom_range(0, 2) != 0);
      pre_rdy = (m_fifo.size() != DEPTH);
      step(1'b0, v_r, 2'($urandom_range(0, 2)), next_rob, rnd_data(), e_r);
      if (v_r && pre_rdy) begin
        sent++;
        next_rob++;
      end
    end
    chk("wrap_sent", 138'(sent), 138'(3 * DEPTH));
    chk("wrap_n", 138'(delivered.size()), 138'(3 * DEPTH));
    for (int i = 0; i < delivered.size(); i++)
      chk("wrap_order", 138'(delivered[i]), 138'(30 + i));

    // reset mid-operation: 3 in FIFO + 1 presented, then discard everything
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd1, ROB_W'(20 + i), rnd_data(), 1'b0);
    chk("mid_cnt", 138'(bus.fifo_cnt), 138'(3));
    chk("mid_vld", 138'(bus.d_bank_valid), 138'(1));
    step(1'b1, 1'b1, 2'd1, 8'd99, rnd_data(), 1'b0);
    delivered.delete();
    idle(1'b1);
    chk("post_rst_vld", 138'(obs_v), 138'(0));
    chk("post_rst_data", 138'(bus.d_bank_data), 138'(0));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("post_rst_stale", 138'(delivered.size()), 138'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_rtn_tx.md
# bank_rtn_tx

Per-bank read-return transmitter. It sits between one SRAM bank controller and the crossbar return path and drives the `d_bankN_*` valid/enable interface into the crossbar. It buffers completed read responses (channel id, ROB id, 128-bit line) in a FIFO. It presents them in arrival order and holds each beat stable under crossbar backpressure. One instance is built per bank (4 total).

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries, power of two, ≥2. Total capacity is DEPTH + 1, counting the output register.
- `ROB_W`, default `` `ROB_WIDTH ``: ROB id width.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sram_rsp_valid` in 1: response beat from the bank controller.
- `sram_rsp_ready` out 1: block can accept a beat this cycle.
- `sram_rsp_chl_id` in 2: destination channel; 0..2 are legal, 3 is illegal.
- `sram_rsp_rob_id` in ROB_W: ROB slot of the request.
- `sram_rsp_data` in 128: line data.
- `d_bank_valid` out 1: return beat to the crossbar.
- `d_bank_enable` in 1: crossbar accepts the beat.
- `d_bank_chl_id` out 2: channel id of the presented beat.
- `d_bank_rob_id` out ROB_W: ROB id of the presented beat.
- `d_bank_data` out 128: data of the presented beat.
- `fifo_cnt` out $clog2(DEPTH)+1: FIFO occupancy, excluding the output register.
- `err_bad_chl` out 1: sticky; set when a beat with chl_id==3 is accepted.

## Operation

- **Input handshake.** A beat is accepted when `sram_rsp_valid & sram_rsp_ready`.
  - `sram_rsp_ready = (fifo_cnt != DEPTH)`, from registered state only. It has no combinational path from `d_bank_enable`.
- **Illegal channel.** An accepted beat with chl_id==3 is consumed and dropped: no FIFO write. `err_bad_chl` is set on the next edge and holds until `rst`.
- **FIFO structure.** Circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, both wrapping modulo DEPTH. A separate count register gives full/empty.
- **Output register.** Holds valid plus payload and drives the `d_bank_*` outputs directly.
- **Output handshake.** A beat completes when `d_bank_valid & d_bank_enable`. While `d_bank_valid & !d_bank_enable`, all `d_bank_*` outputs hold stable.
- **Output load.** The output register loads the FIFO head when the register is empty or completing its handshake this cycle, and the FIFO is non-empty. This pops the FIFO. Otherwise the register clears valid on a handshake.
- **Same-cycle push and pop.** `fifo_cnt` is unchanged and both pointers advance.
- **Ordering.** Strict FIFO; no reordering across channels. The crossbar/ROB handles per-channel order.

## Timing

- **Reset.** On a clock edge with `rst`=1: `d_bank_valid`=0, `d_bank_chl_id`=0, `d_bank_rob_id`=0, `d_bank_data`=0, `fifo_cnt`=0, `err_bad_chl`=0, pointers=0. `sram_rsp_ready` is 1 from the first cycle after reset.
- **Reset mid-operation.** All buffered and presented beats are discarded with no handshake.
- **Latency, base build.** A beat accepted in cycle N is written to the FIFO at the end of N. It loads into the output register at the end of N+1. `d_bank_valid` is 1 in N+2 at the earliest.
- **Throughput.** One beat per cycle sustained when `d_bank_enable` is held high.
- **Full FIFO.** With `fifo_cnt`==DEPTH, `sram_rsp_ready`=0 even if a pop occurs in the same cycle. Ready returns in the cycle after the pop.
- **Empty FIFO with idle output register.** Outputs hold their last payload with valid=0.

## Configuration

- `BANK_RTN_BYPASS_EN` defined: an accepted legal beat bypasses the FIFO under two conditions in the same cycle:
  - the FIFO is empty;
  - the output register is empty or completing its handshake.
  
  The beat loads directly into the output register at the end of N, so `d_bank_valid`=1 in N+1. `fifo_cnt` stays 0.
- `BANK_RTN_BYPASS_EN` undefined: every beat passes through the FIFO, with latency N+2 as above.
- Ordering, backpressure and reset behaviour are identical in both builds.

## Test plan

- **Single beat.** After reset, send one beat {chl 1, rob 5, data 0xA5..A5} with `d_bank_enable`=1. Required: `d_bank_valid` pulses for 1 cycle in N+2 (N+1 with bypass), carrying chl 1 / rob 5 / 0xA5..A5. `fifo_cnt` ends at 0.
- **Backpressure fill.** Hold `d_bank_enable`=0 and stream beats with rob 0,1,2,… (DEPTH=4). Required: 5 beats accepted, `sram_rsp_ready`=0 after the 5th, `fifo_cnt`=4, outputs frozen on rob 0. Release enable: rob 0..4 emerge in order on consecutive cycles.
- **Simultaneous push/pop at full.** At `fifo_cnt`=4, raise `d_bank_enable` with `sram_rsp_valid`=1. Required: no accept that cycle, `fifo_cnt`=3 next cycle, the beat is accepted in the following cycle.
- **Illegal channel.** Send chl_id 3 between two legal beats (rob 7 and rob 8). Required: `err_bad_chl`=1 from the next cycle and sticky, only rob 7 and rob 8 appear at the output.
- **Wrap-around.** Stream 3×DEPTH beats with random `d_bank_enable` stalls. Required: rob ids emerge in exact order with no loss or duplication, across pointer wrap.
- **Reset mid-operation.** Assert `rst` for 1 cycle with 3 beats buffered and `d_bank_valid`=1. Required: all outputs 0 the next cycle, `fifo_cnt`=0, no stale beat is presented afterwards.
